uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame, LSB first.
REQ-002 Parameter SB_TICKS, default 16: oversample ticks spanning the stop bit.
REQ-003 Parameter BAUD_DIV, default 163: clocks per oversample tick (16x oversampling).
REQ-004 i_clk  in  1  single system clock; all state changes on the rising edge.
REQ-005 i_reset  in  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-006 i_rx  in  1  serial line, idle high, asynchronous to i_clk.
REQ-007 o_rx  out  DATA_BITS  last correctly framed byte; held until the next good frame.
REQ-008 o_rx_done_tick  out  1  one-clock pulse, o_rx valid in the same cycle.
REQ-009 o_frame_err  out  1  one-clock pulse when the stop bit samples low.
REQ-010 o_busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-011 i_rx SHALL pass a 2-flop synchronizer; the FSM SHALL see only the synchronized value (2-clock latency).
REQ-012 Tick counter SHALL count 0..BAUD_DIV-1 free-running, wrap to 0, and assert internal tick for one clock when at BAUD_DIV-1.
REQ-013 FSM states SHALL be IDLE, START, DATA and STOP, with oversample counter s and bit counter n.
REQ-014 IDLE: on synchronized rx=0 -> START, s=0; no tick required.
REQ-015 START, on tick: at s=7, if rx=0 -> DATA with s=0, n=0, else -> IDLE (glitch reject, no outputs); otherwise s++.
REQ-016 DATA, on tick: at s=15, s=0 and shift register = {rx, reg[DATA_BITS-1:1]}; then n=DATA_BITS-1 -> STOP, else n++; otherwise s++.
REQ-017 STOP, on tick: at s=SB_TICKS-1 -> IDLE; otherwise s++.
REQ-018 On the STOP->IDLE transition with rx=1: load o_rx from the shift register and pulse o_rx_done_tick in the same clock.
REQ-019 On the STOP->IDLE transition with rx=0: pulse o_frame_err only; o_rx unchanged; no done pulse.
REQ-020 o_rx_done_tick and o_frame_err SHALL never be high together and SHALL each last exactly one clock.
REQ-021 Counters s and n SHALL advance only on tick clocks; non-tick clocks hold all FSM state.
REQ-022 A new start bit is accepted in the clock after returning to IDLE; back-to-back frames SHALL be received without loss.
REQ-023 A line held low continuously SHALL produce framing errors, never done pulses.

Reset
REQ-024 While i_reset=0: FSM=IDLE; s, n, tick counter and shift register = 0; o_rx=0; o_rx_done_tick=0; o_frame_err=0; o_busy=0; synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no done or error pulse; reception restarts at the next falling edge after release.

Verification (BAUD_DIV=4, so 1 bit = 64 clocks)
REQ-026 Reset, i_rx=1 held -> all outputs 0, o_busy=0, for 1000 clocks.
REQ-027 Frame 0x5A, stop=1 -> exactly one o_rx_done_tick; o_rx=0x5A; o_frame_err stays 0; o_busy falls in the pulse cycle.
REQ-028 Low glitch of 8 clocks on idle line -> START aborts to IDLE; no done or error pulse; o_rx unchanged.
REQ-029 Frame 0xA5 received, then frame 0xFF with stop=0 -> one o_frame_err pulse; no done pulse; o_rx remains 0xA5.
REQ-030 Back-to-back frames 0x00 then 0xFF, no idle gap -> two done pulses with o_rx=0x00, then 0xFF.
REQ-031 i_reset=0 for 3 clocks during DATA bit 4 -> outputs cleared, no pulses; next frame 0x3C -> o_rx=0x3C with one done pulse.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 2-flop input sync, LSB-first frames.
// Ports: i_clk, i_reset (async, active-low), i_rx serial in; o_rx data, o_rx_done_tick / o_frame_err pulses, o_busy.
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICKS  = 16,
    parameter int BAUD_DIV  = 163
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_rx,
    output logic                 o_rx_done_tick,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int TW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int SMAX = (SB_TICKS > 16) ? SB_TICKS : 16;
    localparam int SW   = $clog2(SMAX);
    localparam int NW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state_q, state_d;
    logic [SW-1:0]          s_q, s_d;
    logic [NW-1:0]          n_q, n_d;
    logic [DATA_BITS-1:0]   sh_q, sh_d;
    logic [DATA_BITS-1:0]   rx_d;
    logic                   done_d, err_d;
    logic [TW-1:0]          tick_cnt;
    logic                   tick;
    logic                   rx_meta, rx_sync;

    // Synchronizer flops idle high so reset never looks like a start bit.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

    assign tick = (tick_cnt == TW'(BAUD_DIV - 1));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)  tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TW'(1);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q        <= IDLE;
            s_q            <= '0;
            n_q            <= '0;
            sh_q           <= '0;
            o_rx           <= '0;
            o_rx_done_tick <= 1'b0;
            o_frame_err    <= 1'b0;
        end else begin
            state_q        <= state_d;
            s_q            <= s_d;
            n_q            <= n_d;
            sh_q           <= sh_d;
            o_rx           <= rx_d;
            o_rx_done_tick <= done_d;
            o_frame_err    <= err_d;
        end
    end

    // Pulses are registered so they coincide with the return to IDLE.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        sh_d    = sh_q;
        rx_d    = o_rx;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_sync) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == SW'(7)) begin
                        s_d = '0;
                        if (!rx_sync) begin
                            state_d = DATA;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == SW'(15)) begin
                        s_d  = '0;
                        sh_d = {rx_sync, sh_q[DATA_BITS-1:1]};
                        if (n_q == NW'(DATA_BITS - 1)) state_d = STOP;
                        else                           n_d = n_q + NW'(1);
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == SW'(SB_TICKS - 1)) begin
                        state_d = IDLE;
                        s_d     = '0;
                        if (rx_sync) begin
                            rx_d   = sh_q;
                            done_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at BAUD_DIV=4 (64 clocks per bit).
// Expected frame outcomes are queued at send time and popped on each pulse.
module tb_uart_rx;

    localparam int BIT = 64;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] dout;
    logic       done;
    logic       ferr;
    logic       busy;

    int   total;
    int   bad;
    int   done_cnt;
    int   err_cnt;
    exp_t q[$];

    uart_rx #(
        .DATA_BITS(8),
        .SB_TICKS (16),
        .BAUD_DIV (4)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_rx          (rx),
        .o_rx          (dout),
        .o_rx_done_tick(done),
        .o_frame_err   (ferr),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stop,
                        input int stop_len);
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(d[i], BIT);
        hold(stop, stop_len);
        rx = 1'b1;
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (done || ferr) begin
            exp_t e;
            chk("not_both", done & ferr, 1'b0);
            chk("busy_at_pulse", busy, 1'b0);
            chk("q_nonempty", q.size() != 0, 1'b1);
            if (done) done_cnt++;
            if (ferr) err_cnt++;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("kind_err", ferr, e.err);
                chk(e.err ? "rx_hold" : "rx_data", dout, e.data);
            end
        end
    end

    initial begin
        logic any;
        total    = 0;
        bad      = 0;
        done_cnt = 0;
        err_cnt  = 0;
        rx       = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rx", dout, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pulses", {done, ferr}, 2'b00);
        rst_n = 1'b1;

        any = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            any = any | done | ferr | busy | (|dout);
        end
        chk("idle_1000", any, 1'b0);

        q.push_back('{1'b0, 8'h5A});
        send(8'h5A, 1'b1, BIT);
        hold(1'b1, 200);
        chk("5a_done", done_cnt, 1);
        chk("5a_err", err_cnt, 0);
        chk("5a_rx", dout, 8'h5A);

        hold(1'b0, 8);
        chk("glitch_busy", busy, 1'b1);
        hold(1'b1, 100);
        chk("glitch_idle", busy, 1'b0);
        chk("glitch_rx", dout, 8'h5A);
        chk("glitch_cnt", done_cnt + err_cnt, 1);

        q.push_back('{1'b0, 8'hA5});
        send(8'hA5, 1'b1, BIT);
        q.push_back('{1'b1, 8'hA5});
        send(8'hFF, 1'b0, 48);
        hold(1'b1, 200);
        chk("ferr_err", err_cnt, 1);
        chk("ferr_done", done_cnt, 2);
        chk("ferr_rx", dout, 8'hA5);

        q.push_back('{1'b0, 8'h00});
        q.push_back('{1'b0, 8'hFF});
        send(8'h00, 1'b1, BIT);
        send(8'hFF, 1'b1, BIT);
        hold(1'b1, 200);
        chk("b2b_done", done_cnt, 4);
        chk("b2b_rx", dout, 8'hFF);

        hold(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(i >= 2, BIT);
        hold(1'b1, BIT / 2);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_rx", dout, 8'h00);
        chk("abort_busy", busy, 1'b0);
        rst_n = 1'b1;
        hold(1'b1, 300);
        chk("abort_cnt", done_cnt + err_cnt, 5);
        chk("abort_idle", busy, 1'b0);

        q.push_back('{1'b0, 8'h3C});
        send(8'h3C, 1'b1, BIT);
        hold(1'b1, 200);
        chk("3c_done", done_cnt, 5);
        chk("3c_rx", dout, 8'h3C);
        chk("3c_err", err_cnt, 1);

        for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
        chk("q_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
